// File: rtl/async_fifo_pkg.sv
// Shared async FIFO definitions: default pointer width, reset values, Gray encode helper.
// Optional almost_full logic in the write handler is enabled by ASYNC_FIFO_ALMOST_FULL_EN.
package async_fifo_pkg;

  localparam int unsigned DefaultWidth = 3;

  localparam logic RstFull       = 1'b0;
  localparam logic RstAlmostFull = 1'b0;
  localparam logic RstOverflow   = 1'b0;

  // Callers cast the result back to their pointer width.
  function automatic logic [31:0] bin2gray(input logic [31:0] bin);
    return bin ^ (bin >> 1);
  endfunction

endpackage

// File: rtl/write_pointer_handler_if.sv
// Write-side FIFO port bundle: requests and read pointer in, pointers and status out.
interface write_pointer_handler_if
  import async_fifo_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) ();

  logic             w_en;
  logic [WIDTH:0]   g_rptr_sync;
  logic             ovf_clr;
  logic             w_accept;
  logic [WIDTH:0]   b_wptr;
  logic [WIDTH:0]   g_wptr;
  logic             full;
  logic             almost_full;
  logic [WIDTH:0]   wlevel;
  logic             overflow;

  modport master (
    output w_en, g_rptr_sync, ovf_clr,
    input  w_accept, b_wptr, g_wptr, full, almost_full, wlevel, overflow
  );

  modport slave (
    input  w_en, g_rptr_sync, ovf_clr,
    output w_accept, b_wptr, g_wptr, full, almost_full, wlevel, overflow
  );

endinterface

// File: rtl/gray_to_bin.sv
// Gray-to-binary pointer conversion as a combinational XOR prefix chain from the MSB down.
module gray_to_bin #(
  parameter int unsigned WIDTH = 3
) (
  input  logic [WIDTH:0] i_gray,
  output logic [WIDTH:0] o_bin
);

  logic [WIDTH:0] w_bin;

  always_comb begin
    w_bin        = '0;
    w_bin[WIDTH] = i_gray[WIDTH];
    for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
      w_bin[i] = w_bin[i+1] ^ i_gray[i];
    end
  end

  assign o_bin = w_bin;

endmodule

// File: rtl/write_pointer_handler.sv
// Write-domain pointer/status block of the async FIFO: pointers, full, level, sticky overflow.
// almost_full is computed only when ASYNC_FIFO_ALMOST_FULL_EN is defined, else tied to 0.
module write_pointer_handler
  import async_fifo_pkg::*;
#(
  parameter int unsigned WIDTH        = DefaultWidth,
  parameter int unsigned AFULL_THRESH = 6
) (
  input logic                    wclk,
  input logic                    wrst_n,
  write_pointer_handler_if.slave bus
);

  logic [WIDTH:0] r_b_wptr;
  logic [WIDTH:0] r_g_wptr;
  logic [WIDTH:0] r_wlevel;
  logic           r_full;
  logic           r_almost_full;
  logic           r_overflow;

  logic           w_accept;
  logic [WIDTH:0] w_b_wptr_next;
  logic [WIDTH:0] w_g_wptr_next;
  logic [WIDTH:0] w_b_rptr_sync;
  logic [WIDTH:0] w_full_cmp;
  logic [WIDTH:0] w_wlevel_next;
  logic           w_full_next;
  logic           w_almost_full_next;
  logic           w_overflow_next;

  gray_to_bin #(
    .WIDTH (WIDTH)
  ) u_rptr_g2b (
    .i_gray (bus.g_rptr_sync),
    .o_bin  (w_b_rptr_sync)
  );

  always_comb begin
    w_accept      = bus.w_en & ~r_full;
    w_b_wptr_next = r_b_wptr + (WIDTH+1)'(w_accept);
    w_g_wptr_next = (WIDTH+1)'(bin2gray(32'(w_b_wptr_next)));
    // Full when the write pointer is one lap ahead: top two Gray bits inverted, rest equal.
    w_full_cmp    = {~bus.g_rptr_sync[WIDTH:WIDTH-1], bus.g_rptr_sync[WIDTH-2:0]};
    w_full_next   = (w_g_wptr_next == w_full_cmp);
    w_wlevel_next = w_b_wptr_next - w_b_rptr_sync;
    // Set wins over clear.
    w_overflow_next = (bus.w_en & r_full) | (r_overflow & ~bus.ovf_clr);
  end

`ifdef ASYNC_FIFO_ALMOST_FULL_EN
  assign w_almost_full_next = (32'(w_wlevel_next) >= AFULL_THRESH);
`else
  logic [31:0] w_unused_thresh;
  assign w_unused_thresh    = AFULL_THRESH;
  assign w_almost_full_next = 1'b0;
`endif

  always_ff @(posedge wclk) begin
    if (!wrst_n) begin
      r_b_wptr      <= '0;
      r_g_wptr      <= '0;
      r_wlevel      <= '0;
      r_full        <= RstFull;
      r_almost_full <= RstAlmostFull;
      r_overflow    <= RstOverflow;
    end else begin
      r_b_wptr      <= w_b_wptr_next;
      r_g_wptr      <= w_g_wptr_next;
      r_wlevel      <= w_wlevel_next;
      r_full        <= w_full_next;
      r_almost_full <= w_almost_full_next;
      r_overflow    <= w_overflow_next;
    end
  end

  assign bus.w_accept    = w_accept;
  assign bus.b_wptr      = r_b_wptr;
  assign bus.g_wptr      = r_g_wptr;
  assign bus.full        = r_full;
  assign bus.almost_full = r_almost_full;
  assign bus.wlevel      = r_wlevel;
  assign bus.overflow    = r_overflow;

endmodule

// File: tb/tb_write_pointer_handler.sv
// Directed bench for write_pointer_handler (WIDTH=3, AFULL_THRESH=6) with an expected-value queue.
module tb_write_pointer_handler;

`ifdef ASYNC_FIFO_ALMOST_FULL_EN
  localparam logic AfEn = 1'b1;
`else
  localparam logic AfEn = 1'b0;
`endif

  typedef struct {
    logic [3:0] b;
    logic [3:0] g;
    logic       full;
    logic       af;
    logic [3:0] lvl;
    logic       ovf;
  } exp_t;

  logic wclk;
  logic wrst_n;
  int   checks = 0;
  int   errors = 0;
  exp_t sb_q[$];

  write_pointer_handler_if #(.WIDTH(3)) bus ();

  write_pointer_handler #(
    .WIDTH        (3),
    .AFULL_THRESH (6)
  ) dut (
    .wclk   (wclk),
    .wrst_n (wrst_n),
    .bus    (bus)
  );

  initial wclk = 1'b0;
  always #5 wclk = ~wclk;

  initial begin
    #100000;
    $display("FAIL watchdog observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  function automatic logic [3:0] gray4(input logic [3:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, queue the expected post-edge state, then compare after the edge.
  task automatic step(input logic rst_n, input logic en, input logic [3:0] grp, input logic clr,
                      input bit chk_acc, input logic e_acc, input logic [3:0] e_b,
                      input logic e_full, input logic e_af, input logic [3:0] e_lvl,
                      input logic e_ovf, input string tag);
    exp_t e;
    @(negedge wclk);
    wrst_n          = rst_n;
    bus.w_en        = en;
    bus.g_rptr_sync = grp;
    bus.ovf_clr     = clr;
    e.b    = e_b;
    e.g    = gray4(e_b);
    e.full = e_full;
    e.af   = e_af & AfEn;
    e.lvl  = e_lvl;
    e.ovf  = e_ovf;
    sb_q.push_back(e);
    #1;
    if (chk_acc) chk({tag, ".w_accept"}, 32'(bus.w_accept), 32'(e_acc));
    @(posedge wclk);
    #1;
    e = sb_q.pop_front();
    chk({tag, ".b_wptr"},      32'(bus.b_wptr),      32'(e.b));
    chk({tag, ".g_wptr"},      32'(bus.g_wptr),      32'(e.g));
    chk({tag, ".full"},        32'(bus.full),        32'(e.full));
    chk({tag, ".almost_full"}, 32'(bus.almost_full), 32'(e.af));
    chk({tag, ".wlevel"},      32'(bus.wlevel),      32'(e.lvl));
    chk({tag, ".overflow"},    32'(bus.overflow),    32'(e.ovf));
  endtask

  initial begin
    wrst_n          = 1'b0;
    bus.w_en        = 1'b1;
    bus.g_rptr_sync = 4'b0000;
    bus.ovf_clr     = 1'b0;

    // Reset with writes requested: nothing moves.
    step(0, 1, 4'b0000, 0, 0, 0, 4'd0, 0, 0, 4'd0, 0, "rst0");
    step(0, 1, 4'b0000, 0, 1, 1, 4'd0, 0, 0, 4'd0, 0, "rst1");

    // Fill eight slots against an idle reader.
    for (int i = 1; i <= 8; i++) begin
      step(1, 1, 4'b0000, 0, 1, 1, 4'(i), (i == 8), (i >= 6), 4'(i), 0,
           $sformatf("fill%0d", i));
    end

    // Writes while full are dropped and flag overflow.
    for (int i = 0; i < 3; i++) begin
      step(1, 1, 4'b0000, 0, 1, 0, 4'd8, 1, 1, 4'd8, 1, $sformatf("ovf%0d", i));
    end
    step(1, 0, 4'b0000, 0, 1, 0, 4'd8, 1, 1, 4'd8, 1, "ovf_hold");
    step(1, 1, 4'b0000, 1, 1, 0, 4'd8, 1, 1, 4'd8, 1, "ovf_set_wins");
    step(1, 0, 4'b0000, 1, 1, 0, 4'd8, 1, 1, 4'd8, 0, "ovf_clr");

    // Reader frees one then two more slots.
    step(1, 0, 4'b0001, 0, 1, 0, 4'd8, 0, 1, 4'd7, 0, "rel1");
    step(1, 0, 4'b0010, 0, 1, 0, 4'd8, 0, 0, 4'd5, 0, "rel3");

    // Climb to level 7, then write and read together.
    step(1, 1, 4'b0010, 0, 1, 1, 4'd9,  0, 1, 4'd6, 0, "climb6");
    step(1, 1, 4'b0010, 0, 1, 1, 4'd10, 0, 1, 4'd7, 0, "climb7");
    step(1, 1, 4'b0110, 0, 1, 1, 4'd11, 0, 1, 4'd7, 0, "simul");

    // Reset mid-operation with a write requested.
    step(0, 1, 4'b0110, 0, 1, 1, 4'd0, 0, 0, 4'd0, 0, "rst_mid");

    // Wrap: reader trails the next write pointer by two.
    for (int k = 1; k <= 20; k++) begin
      step(1, 1, (k >= 2) ? gray4(4'(k - 2)) : 4'b0000, 0, 1, 1, 4'(k), 0, 0,
           (k == 1) ? 4'd1 : 4'd2, 0, $sformatf("wrap%0d", k));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/write_pointer_handler.md
# write_pointer_handler

Write-side pointer and status block of the asynchronous FIFO, living entirely in the write clock domain. It advances the binary and Gray write pointers on accepted writes and produces a registered `full` flag from the synchronized Gray read pointer. It also produces a fill-level estimate, an `almost_full` warning and a sticky overflow indicator. It mirrors the read-side pointer handler and feeds `g_wptr` to the write→read synchronizer.

## Interface
- `WIDTH`, 3: address bits; FIFO depth = 2**WIDTH; pointers are WIDTH+1 bits; WIDTH ≥ 2.
- `AFULL_THRESH`, 6: fill level at or above which `almost_full` asserts; range 1..2**WIDTH.

Ports:
- `wclk`  in  1  write clock; single clock; all state on rising edge.
- `wrst_n`  in  1  reset, synchronous, active-low.
- `w_en`  in  1  write request.
- `g_rptr_sync`  in  WIDTH+1  Gray read pointer, already synchronized into wclk.
- `ovf_clr`  in  1  clears sticky `overflow`.
- `w_accept`  out  1  combinational, `w_en & !full`; drives the RAM write enable.
- `b_wptr`  out  WIDTH+1  binary write pointer; low WIDTH bits form the RAM write address.
- `g_wptr`  out  WIDTH+1  Gray write pointer, registered.
- `full`  out  1  registered full flag.
- `almost_full`  out  1  registered, level ≥ AFULL_THRESH.
- `wlevel`  out  WIDTH+1  registered fill estimate, 0..2**WIDTH.
- `overflow`  out  1  sticky: write attempted while full.

## Operation
- `b_wptr_next = b_wptr + w_accept`, modulo 2**(WIDTH+1).
- `g_wptr_next = (b_wptr_next >> 1) ^ b_wptr_next`.
- `full_next` is true when `g_wptr_next == {~g_rptr_sync[WIDTH:WIDTH-1], g_rptr_sync[WIDTH-2:0]}`.
- `b_rptr_sync = gray_to_bin(g_rptr_sync)`.
- `wlevel_next = b_wptr_next - b_rptr_sync`, unsigned, modulo 2**(WIDTH+1).
- `almost_full_next` is true when `wlevel_next >= AFULL_THRESH`.
- Overflow:
  - Set when `w_en & full`.
  - Cleared by `ovf_clr`.
  - Set wins over clear in the same cycle.
- Writes while full are dropped: the pointer holds and nothing reaches the RAM.
- Wrap-around: the pointer rolls from all-ones to 0 (Gray `100..0` → `000..0`) with no false `full`; the extra MSB distinguishes full from empty.
- Simultaneous accepted write and read-pointer advance: both are reflected in the same update. Level is unchanged and `full` cannot assert.
- `g_rptr_sync` is sampled every cycle. Being pessimistic (stale) is safe: it can only delay deassertion of `full`/`almost_full`, never cause a false deassertion.

## Timing
- Reset, when `wrst_n` is low at a wclk edge:
  - `b_wptr`, `g_wptr`, `wlevel` = 0.
  - `full`, `almost_full`, `overflow` = 0.
  - `w_en` is ignored during that cycle.
- Reset mid-operation: the same values apply at the next edge. There is no partial state and no handshake with the read side; the FIFO-level reset scheme is responsible for resetting both domains.
- Write latency: a write accepted at edge N updates the pointers at edge N.
  - `full`/`almost_full`/`wlevel` reflect that write at the same edge, computed from the next-state pointer.
  - The write that fills the last slot therefore asserts `full` together with the pointer update, so no extra write can slip in.
- Read release: a `g_rptr_sync` change between edges N-1 and N is reflected in `full`/`wlevel`/`almost_full` at edge N. This is one cycle of latency in addition to the external synchronizer latency.
- `w_accept` is combinational and valid in the same cycle as `w_en`.

## Configuration
- Macro: `ASYNC_FIFO_ALMOST_FULL_EN`.
- Defined: `almost_full` logic is present as specified above.
- Undefined:
  - `almost_full` is tied to 0 and `AFULL_THRESH` is unused.
  - `wlevel`, `full` and `overflow` are unaffected.
  - The port list is identical in both builds.

## Structure
- Shared package `async_fifo_pkg` holds:
  - Default WIDTH constant.
  - `bin2gray` function, used by both pointer handlers.
  - Reset-value constants for status flags.
- Sub-module `gray_to_bin`, parameterized on WIDTH: converts `g_rptr_sync` to binary with a combinational XOR prefix chain. The read side reuses it for `g_wptr_sync`.

## Test plan
All scenarios use WIDTH=3, AFULL_THRESH=6, macro defined.
- **Reset:** `wrst_n`=0 for 2 edges with `w_en`=1 → all outputs 0; the pointer does not move.
- **Fill:** `g_rptr_sync`=0, `w_en`=1 for 8 edges →
  - `b_wptr` goes 1..8.
  - `almost_full`=1 after the 6th edge.
  - After the 8th edge: `full`=1, `g_wptr`=4'b1100, `wlevel`=8.
- **Overflow:** while full, `w_en`=1 for 3 edges →
  - `w_accept`=0, `b_wptr` stays 8.
  - `overflow`=1, held after `w_en` drops.
  - `ovf_clr`=1 together with `w_en`=1 → stays 1; `ovf_clr` alone → 0.
- **Release:** `g_rptr_sync`=4'b0001 → next edge `full`=0, `wlevel`=7, `almost_full`=1. `g_rptr_sync`=4'b0010 (binary 3) → `wlevel`=5, `almost_full`=0.
- **Wrap:** 20 writes with `g_rptr_sync` tracking `g_wptr` two cycles late →
  - `b_wptr` 15→0; `g_wptr` 4'b1000→4'b0000.
  - `full` never asserts; `wlevel` ≤ 2.
- **Simultaneous:** at `wlevel`=7, one accepted write plus a one-step `g_rptr_sync` advance in the same cycle → `wlevel` stays 7, `full` stays 0.
